// File: rtl/int_to_float.sv
// rtl/int_to_float.sv - 16-bit signed integer to IEEE-754 single conversion
// Sequential normaliser: one left shift per cycle until the leading one reaches bit 15.
module int_to_float (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] intin,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] floatout,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        sign_q;
    logic        sign_d;
    logic [15:0] mag_q;
    logic [15:0] mag_d;
    logic [7:0]  exp_q;
    logic [7:0]  exp_d;
    logic [31:0] float_q;
    logic [31:0] float_d;
    logic [15:0] abs_in;

    // Two's-complement negate; -32768 wraps to 0x8000, which is the correct magnitude.
    assign abs_in = intin[15] ? (~intin + 16'd1) : intin;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            mag_q   <= 16'd0;
            exp_q   <= 8'd0;
            float_q <= 32'd0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            float_q <= float_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        float_d = float_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = intin[15];
                    mag_d   = abs_in;
                    exp_d   = 8'd142;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mag_q == 16'd0) begin
                    float_d = 32'd0;
                    state_d = DONE;
                end else if (mag_q[15]) begin
                    // Leading one is the implicit bit; the remaining 15 bits fill the mantissa top.
                    float_d = {sign_q, exp_q, mag_q[14:0], 8'd0};
                    state_d = DONE;
                end else begin
                    mag_d = {mag_q[14:0], 1'b0};
                    exp_d = exp_q - 8'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign floatout  = float_q;

endmodule

// File: tb/tb_int_to_float.sv
// tb/tb_int_to_float.sv - randomized self-checking bench for int_to_float
// Reference derives the single-precision word and latency from the double-precision encoding.
module tb_int_to_float;

    logic        clk;
    logic        reset_n;
    logic [15:0] intin;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] floatout;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    int_to_float dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .intin     (intin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .floatout  (floatout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void ref_conv(input logic [15:0] v, output logic [31:0] f, output int lat);
        int       iv;
        real      r;
        logic [63:0] d;
        int       e;
        iv = int'($signed(v));
        if (iv == 0) begin
            f   = 32'd0;
            lat = 1;
        end else begin
            r = iv;
            d = $realtobits(r);
            e = int'(d[62:52]) - 1023;
            f = {d[63], 8'(e + 127), d[51:29]};
            lat = 16 - e;
        end
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Starts #1 after an edge with the DUT in IDLE.
    task automatic run(input logic [15:0] v, input int hold, input bit noisy, input string tag);
        logic [31:0] exp_f;
        int          exp_lat;
        int          lat;
        ref_conv(v, exp_f, exp_lat);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        intin     = v;
        out_ready = 1'b0;
        step();
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (noisy) begin
                in_valid = 1'($urandom);
                intin    = 16'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_floatout"}, floatout, exp_f);
        for (int i = 0; i < hold; i++) begin
            if (noisy) begin
                in_valid = 1'b1;
                intin    = 16'($urandom);
            end
            step();
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
            chk({tag, "_hold_data"}, floatout, exp_f);
        end
        out_ready = 1'b1;
        if (noisy) in_valid = 1'b1;
        step();
        chk({tag, "_pulse_end"}, 32'(out_valid), 32'd0);
        chk({tag, "_no_reaccept"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        logic [15:0] vec [5];
        int          seen;
        vec[0] = 16'hFFFF;
        vec[1] = 16'h0000;
        vec[2] = 16'd1000;
        vec[3] = 16'h7FFF;
        vec[4] = 16'h8000;

        reset_n   = 1'b0;
        intin     = 16'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_floatout", floatout, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        run(16'd1, 0, 1'b0, "one");
        chk("one_const", floatout, 32'h3F800000);
        for (int i = 0; i < 5; i++) run(vec[i], 0, 1'b0, "seq");
        run(16'd16384, 10, 1'b0, "stall");
        chk("stall_const", floatout, 32'h46800000);
        run(16'd300, 3, 1'b1, "noisy");

        // Abort mid-normalisation: no result may ever appear.
        in_valid = 1'b1;
        intin    = 16'd1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        reset_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_floatout", floatout, 32'd0);
        step();
        reset_n = 1'b1;
        #3;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) seen++;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        run(16'd2, 0, 1'b0, "after_abort");
        chk("after_abort_const", floatout, 32'h40000000);

        run(16'h0001, 0, 1'b0, "edge_p1");
        run(16'hFFFF, 1, 1'b0, "edge_m1");
        run(16'h4000, 0, 1'b1, "edge_4000");
        run(16'hC000, 0, 1'b1, "edge_c000");

        for (int i = 0; i < 400; i++) begin
            run(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/int_to_float.md
INT_TO_FLOAT -- requirements
Module: int_to_float

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port intin, input, 16 bits, signed two's-complement sample to convert.
REQ-004 SHALL have port in_valid, input, 1 bit: intin is valid this cycle.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a sample this cycle.
REQ-006 SHALL have port floatout, output, 32 bits: IEEE-754 single-precision result.
REQ-007 SHALL have port out_valid, output, 1 bit: floatout holds a completed result.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts floatout this cycle.
REQ-009 SHALL have no parameters.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, NORM, DONE.
REQ-011 SHALL drive in_ready = 1 only in IDLE, combinationally from state.
REQ-012 SHALL drive out_valid = 1 only in DONE, combinationally from state.
REQ-013 In IDLE with in_valid=1, the block SHALL, at the clock edge:
  - latch sign = intin[15];
  - latch a 16-bit unsigned magnitude (|intin|; -32768 gives 0x8000);
  - set the working exponent to 142 (127+15);
  - enter NORM.
REQ-014 In IDLE with in_valid=0, the block SHALL hold state and all registers.
REQ-015 In NORM with magnitude == 0, the block SHALL, at the next edge, load floatout = 0x00000000 (sign discarded) and enter DONE.
REQ-016 In NORM with magnitude[15] == 1, the block SHALL, at the next edge:
  - load floatout = {sign, exponent[7:0], magnitude[14:0], 8'b0};
  - enter DONE.
REQ-017 In NORM otherwise, the block SHALL, at each edge, shift the magnitude left by 1 and decrement the exponent by 1, remaining in NORM.
REQ-018 Conversion SHALL be exact: no rounding, no saturation, no NaN/Inf/denormal outputs.
REQ-019 Latency from the accepting edge to the edge that raises out_valid SHALL be L+1 cycles, where L = leading zeros of the 16-bit magnitude (0..15):
  - zero input: 1 cycle;
  - magnitude 1: 16 cycles;
  - magnitude 0x8000: 1 cycle.
REQ-020 In DONE, floatout SHALL be held stable until the handshake completes.
REQ-021 In DONE with out_ready=1, the block SHALL enter IDLE at the edge; a new sample SHALL NOT be accepted in that same cycle (in_ready=0 in DONE).
REQ-022 In DONE with out_ready=0, the block SHALL remain in DONE indefinitely.
REQ-023 in_valid and intin SHALL be ignored outside IDLE; changes to intin during NORM/DONE SHALL NOT affect the result.
REQ-024 floatout SHALL retain its last value in IDLE and NORM; only out_valid qualifies it.

Reset
REQ-025 reset_n low SHALL asynchronously force:
  - state = IDLE;
  - floatout = 0x00000000;
  - magnitude, exponent and sign registers = 0;
  - out_valid = 0, in_ready = 1 (as soon as reset_n is low).
REQ-026 Reset asserted mid-NORM or mid-DONE SHALL abort the conversion with no result ever presented.
REQ-027 After reset_n deasserts, the first rising edge SHALL be able to accept a sample.

Verification
REQ-028 intin=1, out_ready=1 -> floatout=0x3F800000, out_valid rises 16 cycles after accept, high for 1 cycle.
REQ-029 intin=-1, 0, 1000, 32767, -32768 sequentially -> 0xBF800000 (16 cyc), 0x00000000 (1 cyc), 0x447A0000 (7 cyc), 0x46FFFE00 (2 cyc), 0xC7000000 (1 cyc).
REQ-030 intin=16384, out_ready=0 for 10 cycles after out_valid -> floatout=0x46800000 held stable, in_ready=0 throughout, single transfer when out_ready rises.
REQ-031 intin toggled randomly with in_valid=1 during NORM -> result matches only the sample accepted in IDLE; no second accept until the DONE handshake completes.
REQ-032 reset_n pulsed low 5 cycles after accepting intin=1 -> outputs go immediately to idle values, out_valid never asserts; next sample intin=2 -> 0x40000000.
REQ-033 Exhaustive sweep of all 65536 inputs against a reference model -> bit-exact floatout and latency L+1 for every value.
